// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Owns the register file's single write port. NUM_REQ writeback sources
//   share it through valid/ready handshakes under round-robin priority. An
//   init sequencer can zero every register, one register per cycle.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   req_valid_i    per-requester write request
//   req_ready_o    per-requester grant (combinational, one-hot or zero)
//   req_addr_i     flattened addresses, requester i at [i*REGADDR_WIDTH +: REGADDR_WIDTH]
//   req_data_i     flattened data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   init_start_i   single-cycle pulse that starts the zero sweep
//   init_busy_o    high while the sweep runs
//   init_done_o    one-cycle pulse alongside the last sweep write
//   write_reg_o    register file write address
//   write_data_o   register file write data
//   reg_write_o    register file write enable
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ARB  | round-robin arbitration between requesters
// ST_INIT | zero sweep, one register per cycle, requesters held off

module regfile_wr_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4,
  parameter int NUM_REGS      = 1 << REGADDR_WIDTH,
  parameter int NUM_REQ       = 3,
  parameter bit ZERO_REG      = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*REGADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic                             init_start_i,
  output logic                             init_busy_o,
  output logic                             init_done_o,
  output logic [REGADDR_WIDTH-1:0]         write_reg_o,
  output logic [DATA_WIDTH-1:0]            write_data_o,
  output logic                             reg_write_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [REGADDR_WIDTH-1:0] LAST_REG = REGADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0]         LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [REGADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                     reg_write_q, reg_write_d;
  logic [REGADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     init_done_q, init_done_d;

  logic                     grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [REGADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0]    grant_data;

  // Round-robin pick. Scanning from the farthest offset down to zero lets the
  // nearest valid requester (smallest offset from rr_ptr) overwrite the rest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_addr = '0;
    grant_data = '0;
    req_ready_o = '0;
    if (state_q == ST_ARB && !init_start_i) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (req_valid_i[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        grant_addr = req_addr_i[i*REGADDR_WIDTH +: REGADDR_WIDTH];
        grant_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (grant_vld) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    init_done_d  = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (init_start_i) begin
          state_d = ST_INIT;
        end else if (grant_vld) begin
          rr_ptr_d     = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
          // r0 writes still handshake and advance the pointer, but never
          // reach the register file when r0 is hardwired to zero.
          reg_write_d  = !(ZERO_REG && (grant_addr == '0));
          write_reg_d  = grant_addr;
          write_data_d = grant_data;
        end
      end
      ST_INIT: begin
        reg_write_d  = 1'b1;
        write_reg_d  = cnt_q;
        write_data_d = '0;
        if (cnt_q == LAST_REG) begin
          state_d     = ST_ARB;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      init_done_q  <= init_done_d;
    end
  end

  // The last sweep write returns the FSM to ST_ARB at the same edge that
  // raises init_done, so busy drops exactly when done pulses.
  assign init_busy_o  = (state_q == ST_INIT);
  assign init_done_o  = init_done_q;
  assign reg_write_o  = reg_write_q;
  assign write_reg_o  = write_reg_q;
  assign write_data_o = write_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [11:0] req_addr = '0;
  logic [47:0] req_data = '0;
  logic        init_start = 1'b0;

  logic [2:0]  req_ready;
  logic        init_busy, init_done, reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;

  logic [2:0]  z_ready;
  logic        z_busy, z_done, z_we;
  logic [3:0]  z_wreg;
  logic [15:0] z_wdata;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_WIDTH(16), .REGADDR_WIDTH(4), .NUM_REQ(3), .ZERO_REG(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .init_start_i(init_start),
    .init_busy_o(init_busy), .init_done_o(init_done), .write_reg_o(write_reg),
    .write_data_o(write_data), .reg_write_o(reg_write));

  regfile_wr_arbiter #(.DATA_WIDTH(16), .REGADDR_WIDTH(4), .NUM_REQ(3), .ZERO_REG(1'b0)) dut_z0 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(z_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .init_start_i(init_start),
    .init_busy_o(z_busy), .init_done_o(z_done), .write_reg_o(z_wreg),
    .write_data_o(z_wdata), .reg_write_o(z_we));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending sweep writes are a queue of addresses; the
  // arbiter is a pointer plus "first valid at or after pointer".
  int          m_rr;
  int          sweep_q[$];
  logic        m_we;
  logic [3:0]  m_wa;
  logic [15:0] m_wd;
  bit          m_wa_known;
  logic        m_done;
  logic [15:0] rf[16];

  logic [2:0]  obs_rdy;
  logic        obs_we, obs_done;
  logic [3:0]  obs_wa;

  task automatic model_reset();
    m_rr = 0;
    sweep_q.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    m_wa_known = 1'b1;
    m_done = 1'b0;
  endtask

  task automatic step(input logic [2:0] v, input logic [11:0] a, input logic [47:0] d, input logic ini);
    int g;
    logic [2:0] exp_rdy;
    req_valid = v; req_addr = a; req_data = d; init_start = ini;
    g = -1;
    if (sweep_q.size() == 0 && !ini) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_rr + k) % 3;
        if (g < 0 && v[2'(idx)]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    @(negedge clk);
    obs_rdy = req_ready; obs_we = reg_write; obs_wa = write_reg; obs_done = init_done;
    chk("ready", req_ready, exp_rdy);
    chk("reg_write", reg_write, m_we);
    if (m_wa_known) begin
      chk("write_reg", write_reg, m_wa);
      chk("write_data", write_data, m_wd);
    end
    chk("init_busy", init_busy, sweep_q.size() > 0);
    chk("init_done", init_done, m_done);
    if (reg_write) rf[write_reg] = write_data;
    @(posedge clk);
    if (sweep_q.size() > 0) begin
      m_wa = 4'(sweep_q.pop_front());
      m_wd = '0;
      m_we = 1'b1;
      m_wa_known = 1'b1;
      m_done = (sweep_q.size() == 0);
    end else begin
      m_done = 1'b0;
      if (ini) begin
        m_we = 1'b0;
        for (int r = 0; r < 16; r++) sweep_q.push_back(r);
      end else if (g >= 0) begin
        m_rr = (g + 1) % 3;
        m_wa = a[g*4 +: 4];
        m_wd = d[g*16 +: 16];
        m_we = (m_wa != 4'd0);
        m_wa_known = m_we;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0; init_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_write_reg", write_reg, 4'd0);
    chk("rst_write_data", write_data, 16'd0);
    chk("rst_init_busy", init_busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ready", req_ready, 3'b000);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  v;
    logic [11:0] a;
    logic [47:0] d;
    logic [2:0]  rdy;
    logic        we;
    logic        we_z0;
    logic        chk_w;
    logic [3:0]  wa;
    logic [15:0] wd;
  } row_t;

  localparam logic [11:0] A123 = {4'd3, 4'd2, 4'd1};
  localparam logic [47:0] D123 = {16'h3333, 16'h2222, 16'h1111};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin : main
    row_t rows[13];
    int zero_rdy, done_cnt, done_cyc, nz, first_grant;
    logic [3:0] done_wa;
    logic [2:0] resume_rdy, first_rdy;
    logic grant_done;
    bit found;

    rows[0]  = '{3'b001, {4'd0, 4'd0, 4'd5}, {32'h0, 16'h1234}, 3'b001, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000};
    rows[1]  = '{3'b000, {4'd0, 4'd0, 4'd5}, {32'h0, 16'h1234}, 3'b000, 1'b1, 1'b1, 1'b1, 4'd5, 16'h1234};
    rows[2]  = '{3'b000, 12'h0, 48'h0, 3'b000, 1'b0, 1'b0, 1'b1, 4'd5, 16'h1234};
    rows[3]  = '{3'b111, A123, D123, 3'b010, 1'b0, 1'b0, 1'b1, 4'd5, 16'h1234};
    rows[4]  = '{3'b111, A123, D123, 3'b100, 1'b1, 1'b1, 1'b1, 4'd2, 16'h2222};
    rows[5]  = '{3'b111, A123, D123, 3'b001, 1'b1, 1'b1, 1'b1, 4'd3, 16'h3333};
    rows[6]  = '{3'b111, A123, D123, 3'b010, 1'b1, 1'b1, 1'b1, 4'd1, 16'h1111};
    rows[7]  = '{3'b111, A123, D123, 3'b100, 1'b1, 1'b1, 1'b1, 4'd2, 16'h2222};
    rows[8]  = '{3'b111, A123, D123, 3'b001, 1'b1, 1'b1, 1'b1, 4'd3, 16'h3333};
    rows[9]  = '{3'b010, {4'd3, 4'd0, 4'd1}, {16'h3333, 16'hFFFF, 16'h1111}, 3'b010, 1'b1, 1'b1, 1'b1, 4'd1, 16'h1111};
    rows[10] = '{3'b000, 12'h0, 48'h0, 3'b000, 1'b0, 1'b1, 1'b0, 4'd0, 16'hFFFF};
    rows[11] = '{3'b011, A123, D123, 3'b001, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};
    rows[12] = '{3'b000, 12'h0, 48'h0, 3'b000, 1'b1, 1'b1, 1'b1, 4'd1, 16'h1111};

    // Table: single request, round robin, r0 suppression on both builds.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req_valid = rows[i].v; req_addr = rows[i].a; req_data = rows[i].d; init_start = 1'b0;
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), req_ready, rows[i].rdy);
      chk($sformatf("row%0d_we", i), reg_write, rows[i].we);
      if (rows[i].chk_w) begin
        chk($sformatf("row%0d_wreg", i), write_reg, rows[i].wa);
        chk($sformatf("row%0d_wdata", i), write_data, rows[i].wd);
      end
      chk($sformatf("row%0d_z0_ready", i), z_ready, rows[i].rdy);
      chk($sformatf("row%0d_z0_we", i), z_we, rows[i].we_z0);
      if (rows[i].we_z0) begin
        chk($sformatf("row%0d_z0_wreg", i), z_wreg, rows[i].wa);
        chk($sformatf("row%0d_z0_wdata", i), z_wdata, rows[i].wd);
      end
      chk($sformatf("row%0d_z0_busy", i), {z_busy, z_done}, 2'b00);
      @(posedge clk);
      #1;
    end

    // Init sweep with all requesters pending.
    do_reset();
    for (int i = 0; i < 16; i++) rf[i] = 16'hBEEF ^ 16'(i);
    zero_rdy = 0; done_cnt = 0; done_cyc = -1; done_wa = '0; resume_rdy = '0;
    step(3'b111, A123, D123, 1'b1);
    if (obs_rdy == 3'b000) zero_rdy++;
    for (int c = 1; c <= 17; c++) begin
      step(3'b111, A123, D123, (c == 5));
      if (obs_rdy == 3'b000) zero_rdy++;
      if (obs_done) begin
        done_cnt++;
        done_cyc = c;
        done_wa = obs_wa;
      end
      resume_rdy = obs_rdy;
    end
    chk("sweep_ready_zero_cycles", zero_rdy, 17);
    chk("sweep_done_count", done_cnt, 1);
    chk("sweep_done_cycle", done_cyc, 17);
    chk("sweep_done_addr", done_wa, 4'd15);
    chk("sweep_resume_grant", resume_rdy, 3'b001);
    nz = 0;
    for (int i = 0; i < 16; i++) if (rf[i] != 16'h0) nz++;
    chk("sweep_regfile_nonzero", nz, 0);
    step(3'b000, A123, D123, 1'b0);

    // Reset in the middle of a sweep.
    do_reset();
    step(3'b111, A123, D123, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step(3'b111, A123, D123, 1'b0);
      if (obs_we && obs_wa == 4'd6) found = 1'b1;
    end
    chk("rst_sweep_reached_w6", found, 1'b1);
    #2;
    chk("rst_sweep_w7_shown", {reg_write, write_reg}, {1'b1, 4'd7});
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_sweep_we_low", reg_write, 1'b0);
    chk("rst_sweep_busy_low", init_busy, 1'b0);
    chk("rst_sweep_done_low", init_done, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    done_cnt = 0; first_rdy = '0;
    for (int c = 0; c < 20; c++) begin
      step(3'b111, A123, D123, 1'b0);
      if (c == 0) first_rdy = obs_rdy;
      if (obs_done) done_cnt++;
    end
    chk("rst_sweep_no_done", done_cnt, 0);
    chk("rst_sweep_rr0", first_rdy, 3'b001);

    // init_start together with a request from requester 1.
    do_reset();
    step(3'b010, A123, D123, 1'b1);
    first_grant = -1; grant_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step(3'b010, A123, D123, 1'b0);
      if (obs_rdy[1] && first_grant < 0) begin
        first_grant = c;
        grant_done = obs_done;
      end
    end
    chk("simul_first_grant_cycle", first_grant, 17);
    chk("simul_grant_with_done", grant_done, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(3'($urandom_range(0, 7)), 12'($urandom()), {16'($urandom()), 32'($urandom())},
           ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
